// File: rtl/vec_pkg.sv
// Shared vector and operand-pair types for the vector-math datapath.
package vec_pkg;
   localparam int unsigned D_BITS  = 32;
   localparam int unsigned VEC_LEN = 3;

   typedef logic signed [D_BITS-1:0] comp_t;
   typedef comp_t [VEC_LEN-1:0] vec_t;

   typedef struct packed {
      vec_t x;
      vec_t y;
   } pair_t;
endpackage

// File: rtl/vec_pair_join_pair_buffer.sv
// Show-ahead register FIFO of operand pairs with occupancy output.
module pair_buffer
   import vec_pkg::*;
#(
   parameter  int unsigned DEPTH    = 4,
   localparam int unsigned PTR_BITS = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_push,
   input  pair_t             i_din,
   input  logic              i_pop,
   output pair_t             o_head_c,
   output logic [PTR_BITS:0] o_count
);

   pair_t               r_mem [DEPTH];
   logic [PTR_BITS-1:0] r_wr_ptr;
   logic [PTR_BITS-1:0] r_rd_ptr;
   logic [PTR_BITS:0]   r_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mem    <= '{default: '0};
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + PTR_BITS'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + (PTR_BITS+1)'(1);
            2'b01:   r_count <= r_count - (PTR_BITS+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_c = r_mem[r_rd_ptr];
   assign o_count  = r_count;

endmodule

// File: rtl/vec_pair_join.sv
// Joins two show-ahead operand FIFOs (X, Y) into one buffered pair stream.
module vec_pair_join
   import vec_pkg::*;
#(
   parameter  int unsigned DEPTH    = 4,
   localparam int unsigned PTR_BITS = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  vec_t              x_din,
   input  logic              x_empty,
   output logic              x_rd_en,
   input  vec_t              y_din,
   input  logic              y_empty,
   output logic              y_rd_en,
   output vec_t              x,
   output vec_t              y,
   output logic              out_empty,
   input  logic              out_rd_en,
   output logic [PTR_BITS:0] pair_count
);

   logic              w_push;
   logic              w_pop;
   logic [PTR_BITS:0] w_count;
   pair_t             w_din;
   pair_t             w_head;

   // Push depends only on upstream flags and registered occupancy, never on out_rd_en.
   assign w_push = !reset && !x_empty && !y_empty && (w_count < (PTR_BITS+1)'(DEPTH));
   assign w_pop  = out_rd_en && (w_count != '0);

   assign w_din.x = x_din;
   assign w_din.y = y_din;

   pair_buffer #(.DEPTH(DEPTH)) u_buf (
      .clock    (clock),
      .reset    (reset),
      .i_push   (w_push),
      .i_din    (w_din),
      .i_pop    (w_pop),
      .o_head_c (w_head),
      .o_count  (w_count)
   );

   assign x_rd_en    = w_push;
   assign y_rd_en    = w_push;
   assign x          = w_head.x;
   assign y          = w_head.y;
   assign out_empty  = (w_count == '0);
   assign pair_count = w_count;

endmodule

// File: tb/tb_vec_pair_join.sv
// Self-checking bench for vec_pair_join against a queue-based pairing model.
module tb_vec_pair_join;
   import vec_pkg::*;

   localparam int DEPTH = 4;

   logic clock = 1'b0;
   logic reset;
   vec_t x_din, y_din, x, y;
   logic x_empty, y_empty, x_rd_en, y_rd_en, out_empty, out_rd_en;
   logic [2:0] pair_count;

   vec_t  xq[$];
   vec_t  yq[$];
   pair_t mq[$];

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int add_x;
      int add_y;
      bit rd;
      int exp_cnt;
   } vec_rec_t;

   vec_pair_join #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .x_din(x_din), .x_empty(x_empty), .x_rd_en(x_rd_en),
      .y_din(y_din), .y_empty(y_empty), .y_rd_en(y_rd_en),
      .x(x), .y(y), .out_empty(out_empty), .out_rd_en(out_rd_en),
      .pair_count(pair_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int a, input int b, input int c);
      vec_t v;
      v[0] = a;
      v[1] = b;
      v[2] = c;
      return v;
   endfunction

   function automatic vec_t rv();
      return mk($urandom, $urandom, $urandom);
   endfunction

   task automatic add_pairs(input int nx, input int ny);
      for (int i = 0; i < nx; i++) xq.push_back(rv());
      for (int i = 0; i < ny; i++) yq.push_back(rv());
   endtask

   task automatic check_out();
      chk("out_empty", out_empty, mq.size() == 0);
      chk("pair_count", pair_count, mq.size());
      if (mq.size() != 0) begin
         chk("x_head", x, mq[0].x);
         chk("y_head", y, mq[0].y);
      end
   endtask

   // One clock: drive upstream heads, predict pops, then compare after the edge.
   task automatic step(input bit rd);
      bit    exp_push;
      pair_t p;
      @(negedge clock);
      out_rd_en = rd;
      x_empty   = (xq.size() == 0);
      y_empty   = (yq.size() == 0);
      if (xq.size() != 0) x_din = xq[0];
      if (yq.size() != 0) y_din = yq[0];
      #1;
      exp_push = !x_empty && !y_empty && (mq.size() < DEPTH);
      chk("x_rd_en", x_rd_en, exp_push);
      chk("y_rd_en", y_rd_en, exp_push);
      @(posedge clock);
      if (rd && mq.size() != 0) void'(mq.pop_front());
      if (exp_push) begin
         p.x = xq.pop_front();
         p.y = yq.pop_front();
         mq.push_back(p);
      end
      #1;
      check_out();
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (mq.size() == 0 && (xq.size() == 0 || yq.size() == 0)) break;
         step(1'b1);
      end
      chk("drained", mq.size() == 0 && (xq.size() == 0 || yq.size() == 0), 1'b1);
      xq.delete();
      yq.delete();
   endtask

   vec_rec_t tbl[14];

   initial begin
      tbl = '{
         '{6, 6, 1'b0, 1}, '{0, 0, 1'b0, 2}, '{0, 0, 1'b0, 3}, '{0, 0, 1'b0, 4},
         '{0, 0, 1'b0, 4}, '{0, 0, 1'b1, 3}, '{0, 0, 1'b0, 4}, '{0, 0, 1'b0, 4},
         '{0, 0, 1'b1, 3}, '{0, 0, 1'b1, 3}, '{0, 0, 1'b1, 2}, '{0, 0, 1'b1, 1},
         '{0, 0, 1'b1, 0}, '{0, 0, 1'b1, 0}
      };

      reset = 1'b1;
      x_empty = 1'b1;
      y_empty = 1'b1;
      out_rd_en = 1'b0;
      x_din = '0;
      y_din = '0;
      #2;
      chk("rst_out_empty", out_empty, 1'b1);
      chk("rst_pair_count", pair_count, 0);
      chk("rst_x", x, 0);
      chk("rst_y", y, 0);
      chk("rst_x_rd_en", x_rd_en, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // First pair: one-cycle latency and exact data.
      step(1'b0);
      step(1'b0);
      xq.push_back(mk(1, 2, 3));
      yq.push_back(mk(4, 5, 6));
      step(1'b0);
      chk("first_x", x, mk(1, 2, 3));
      chk("first_y", y, mk(4, 5, 6));
      chk("first_count", pair_count, 1);
      step(1'b0);
      drain();

      // Imbalance: X waits while Y is empty, then pairs in order.
      add_pairs(3, 0);
      for (int i = 0; i < 10; i++) step(1'b0);
      chk("imbal_empty", out_empty, 1'b1);
      add_pairs(0, 3);
      for (int i = 0; i < 6; i++) step(1'b1);
      drain();

      // Table: fill to full with reads held off, single pop, then drain and pop-on-empty.
      foreach (tbl[i]) begin
         add_pairs(tbl[i].add_x, tbl[i].add_y);
         step(tbl[i].rd);
         chk("tbl_count", pair_count, tbl[i].exp_cnt);
      end
      drain();

      // Streaming at count 2 across pointer wrap.
      for (int i = 1; i <= 22; i++) begin
         xq.push_back(mk(32'h0001_0000 * i, i, -i));
         yq.push_back(mk(32'h0001_0000 * i + 1, -i, i));
      end
      step(1'b0);
      step(1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1);
         chk("stream_count", pair_count, 2);
      end
      drain();

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         add_pairs(($urandom_range(0, 9) < 5) ? 1 : 0, ($urandom_range(0, 9) < 5) ? 1 : 0);
         step(1'($urandom_range(0, 1)));
      end
      drain();

      // Asynchronous reset with buffered pairs.
      add_pairs(6, 6);
      step(1'b0);
      step(1'b0);
      step(1'b0);
      chk("pre_rst_count", pair_count, 3);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_out_empty", out_empty, 1'b1);
      chk("arst_count", pair_count, 0);
      chk("arst_x", x, 0);
      chk("arst_y", y, 0);
      chk("arst_x_rd_en", x_rd_en, 1'b0);
      chk("arst_y_rd_en", y_rd_en, 1'b0);
      mq.delete();
      xq.delete();
      yq.delete();
      @(negedge clock);
      x_empty = 1'b1;
      y_empty = 1'b1;
      reset = 1'b0;
      xq.push_back(mk(7, 8, 9));
      yq.push_back(mk(10, 11, 12));
      step(1'b0);
      chk("post_rst_x", x, mk(7, 8, 9));
      chk("post_rst_y", y, mk(10, 11, 12));
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
